// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage: instruction-fetch stage of the 5-stage RISC-V pipeline.
//
// Owns the fetch PC, talks to a variable-latency instruction memory with at
// most one request outstanding, and holds the IF/ID pipeline register that
// feeds the decode stage.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   stall             hazard unit: freeze IF/ID and the fetch PC
//   redirect          EX stage: taken branch/jump, squash IF/ID
//   redirect_pc       new fetch target when redirect=1 (bits [1:0] ignored)
//   imem_req          request valid this cycle (combinational)
//   imem_addr         word-aligned fetch address (combinational)
//   imem_rvalid       response valid, at least one cycle after the request
//   imem_rdata        instruction word, valid with imem_rvalid
//   ir, pc_id, pc4_id IF/ID instruction, its PC and PC+4
//   id_valid          IF/ID holds a real instruction (0 = bubble)
//   fetch_busy        high while a response is awaited (WAIT or DRAIN)
//   pc_sdu            current fetch PC for the debug unit
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] pc_id,
    output logic [31:0] pc4_id,
    output logic        id_valid,
    output logic        fetch_busy,
    output logic [31:0] pc_sdu
);

    // REQ:   issue a request for pc_f
    // WAIT:  a request for pc_f is outstanding
    // HOLD:  response for pc_f captured in hold_buf while ID was stalled
    // DRAIN: a request made stale by a redirect is outstanding; drop it
    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_f_reg;
    logic [31:0] hold_buf_reg;
    logic [31:0] ir_reg;
    logic [31:0] pc_id_reg;
    logic [31:0] pc4_id_reg;
    logic        id_valid_reg;

    logic [31:0] pc_f_plus4;
    logic [31:0] redirect_aligned;

    assign pc_f_plus4       = pc_f_reg + 32'd4;
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    // A new request goes out either from REQ, or in the same cycle an
    // instruction is handed to ID (back-to-back fetch with a 1-cycle memory).
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = {pc_f_reg[31:2], 2'b00};
        case (state_reg)
            S_REQ: begin
                imem_req = 1'b1;
            end
            S_WAIT: begin
                if (!redirect && imem_rvalid && !stall) begin
                    imem_req  = 1'b1;
                    imem_addr = {pc_f_plus4[31:2], 2'b00};
                end
            end
            S_HOLD: begin
                if (!redirect && !stall) begin
                    imem_req  = 1'b1;
                    imem_addr = {pc_f_plus4[31:2], 2'b00};
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_REQ;
            pc_f_reg     <= PC_RESET;
            hold_buf_reg <= NOP;
            ir_reg       <= NOP;
            pc_id_reg    <= 32'd0;
            pc4_id_reg   <= 32'd4;
            id_valid_reg <= 1'b0;
        end else if (redirect) begin
            // Redirect beats stall and any response. If a request is still
            // in flight after this edge, its response must be drained.
            ir_reg       <= NOP;
            id_valid_reg <= 1'b0;
            pc_f_reg     <= redirect_aligned;
            hold_buf_reg <= NOP;
            case (state_reg)
                S_REQ:   state_reg <= S_DRAIN;
                S_WAIT:  state_reg <= imem_rvalid ? S_REQ : S_DRAIN;
                S_DRAIN: state_reg <= imem_rvalid ? S_REQ : S_DRAIN;
                default: state_reg <= S_REQ;
            endcase
        end else begin
            case (state_reg)
                S_REQ: begin
                    state_reg <= S_WAIT;
                    if (!stall) begin
                        ir_reg       <= NOP;
                        id_valid_reg <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (!stall) begin
                            ir_reg       <= imem_rdata;
                            pc_id_reg    <= pc_f_reg;
                            pc4_id_reg   <= pc_f_plus4;
                            id_valid_reg <= 1'b1;
                            pc_f_reg     <= pc_f_plus4;
                        end else begin
                            hold_buf_reg <= imem_rdata;
                            state_reg    <= S_HOLD;
                        end
                    end else if (!stall) begin
                        ir_reg       <= NOP;
                        id_valid_reg <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ir_reg       <= hold_buf_reg;
                        pc_id_reg    <= pc_f_reg;
                        pc4_id_reg   <= pc_f_plus4;
                        id_valid_reg <= 1'b1;
                        pc_f_reg     <= pc_f_plus4;
                        state_reg    <= S_WAIT;
                    end
                end
                default: begin  // S_DRAIN
                    if (imem_rvalid) begin
                        state_reg <= S_REQ;
                    end
                    if (!stall) begin
                        ir_reg       <= NOP;
                        id_valid_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign ir         = ir_reg;
    assign pc_id      = pc_id_reg;
    assign pc4_id     = pc4_id_reg;
    assign id_valid   = id_valid_reg;
    assign fetch_busy = (state_reg == S_WAIT) || (state_reg == S_DRAIN);
    assign pc_sdu     = pc_f_reg;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage: directed, table-driven bench for if_stage.
// Each table row is one clock cycle: the inputs applied in that cycle and the
// outputs expected before the next rising edge. Instruction data returned by
// the memory is derived from the last requested address.
// -----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] pc_id;
    logic [31:0] pc4_id;
    logic        id_valid;
    logic        fetch_busy;
    logic [31:0] pc_sdu;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .pc_id       (pc_id),
        .pc4_id      (pc4_id),
        .id_valid    (id_valid),
        .fetch_busy  (fetch_busy),
        .pc_sdu      (pc_sdu)
    );

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        rv;
        logic        ereq;
        logic [31:0] eaddr;
        logic [31:0] eir;
        logic [31:0] epcid;
        logic        evalid;
        logic        ebusy;
        logic [31:0] epcf;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] dat(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic add(input logic s, input logic r, input logic [31:0] rpc, input logic rv,
                       input logic ereq, input logic [31:0] eaddr, input logic [31:0] eir,
                       input logic [31:0] epcid, input logic ev, input logic eb,
                       input logic [31:0] epcf);
        vec_t v;
        v.stall = s;   v.redir = r;    v.rpc = rpc;     v.rv = rv;
        v.ereq = ereq; v.eaddr = eaddr; v.eir = eir;    v.epcid = epcid;
        v.evalid = ev; v.ebusy = eb;   v.epcf = epcf;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] last_addr;
        logic        req_s;
        logic [31:0] addr_s;

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_rvalid = 1'b0; imem_rdata = 32'd0; last_addr = 32'd0;

        //  stall redir rpc          rv  req addr         ir                 pc_id        val busy pc_f
        add(0, 0, 32'h0,         0,  1, 32'h0,        NOP,               32'h0,         0, 0, 32'h0);
        add(0, 0, 32'h0,         1,  1, 32'h4,        NOP,               32'h0,         0, 1, 32'h0);
        add(0, 0, 32'h0,         1,  1, 32'h8,        dat(32'h0),        32'h0,         1, 1, 32'h4);
        add(0, 0, 32'h0,         1,  1, 32'hC,        dat(32'h4),        32'h4,         1, 1, 32'h8);
        add(0, 0, 32'h0,         0,  0, 32'h0,        dat(32'h8),        32'h8,         1, 1, 32'hC);
        add(0, 0, 32'h0,         0,  0, 32'h0,        NOP,               32'h8,         0, 1, 32'hC);
        add(0, 0, 32'h0,         1,  1, 32'h10,       NOP,               32'h8,         0, 1, 32'hC);
        add(0, 0, 32'h0,         0,  0, 32'h0,        dat(32'hC),        32'hC,         1, 1, 32'h10);
        add(0, 0, 32'h0,         0,  0, 32'h0,        NOP,               32'hC,         0, 1, 32'h10);
        add(1, 0, 32'h0,         1,  0, 32'h0,        NOP,               32'hC,         0, 1, 32'h10);
        add(1, 0, 32'h0,         1,  0, 32'h0,        NOP,               32'hC,         0, 0, 32'h10);
        add(1, 0, 32'h0,         0,  0, 32'h0,        NOP,               32'hC,         0, 0, 32'h10);
        add(0, 0, 32'h0,         0,  1, 32'h14,       NOP,               32'hC,         0, 0, 32'h10);
        add(0, 0, 32'h0,         1,  1, 32'h18,       dat(32'h10),       32'h10,        1, 1, 32'h14);
        add(1, 0, 32'h0,         0,  0, 32'h0,        dat(32'h14),       32'h14,        1, 1, 32'h18);
        add(0, 0, 32'h0,         0,  0, 32'h0,        dat(32'h14),       32'h14,        1, 1, 32'h18);
        add(0, 1, 32'h100,       0,  0, 32'h0,        NOP,               32'h14,        0, 1, 32'h18);
        add(0, 0, 32'h0,         1,  0, 32'h0,        NOP,               32'h14,        0, 1, 32'h100);
        add(0, 0, 32'h0,         0,  1, 32'h100,      NOP,               32'h14,        0, 0, 32'h100);
        add(0, 0, 32'h0,         1,  1, 32'h104,      NOP,               32'h14,        0, 1, 32'h100);
        add(1, 1, 32'h203,       0,  0, 32'h0,        dat(32'h100),      32'h100,       1, 1, 32'h104);
        add(0, 0, 32'h0,         0,  0, 32'h0,        NOP,               32'h100,       0, 1, 32'h200);
        add(0, 0, 32'h0,         1,  0, 32'h0,        NOP,               32'h100,       0, 1, 32'h200);
        add(0, 1, 32'h300,       0,  1, 32'h200,      NOP,               32'h100,       0, 0, 32'h200);
        add(0, 0, 32'h0,         1,  0, 32'h0,        NOP,               32'h100,       0, 1, 32'h300);
        add(0, 0, 32'h0,         0,  1, 32'h300,      NOP,               32'h100,       0, 0, 32'h300);
        add(1, 0, 32'h0,         1,  0, 32'h0,        NOP,               32'h100,       0, 1, 32'h300);
        add(0, 1, 32'h400,       0,  0, 32'h0,        NOP,               32'h100,       0, 0, 32'h300);
        add(0, 0, 32'h0,         1,  1, 32'h400,      NOP,               32'h100,       0, 0, 32'h400);
        add(0, 1, 32'h500,       1,  0, 32'h0,        NOP,               32'h100,       0, 1, 32'h400);
        add(0, 0, 32'h0,         0,  1, 32'h500,      NOP,               32'h100,       0, 0, 32'h500);
        add(0, 0, 32'h0,         1,  1, 32'h504,      NOP,               32'h100,       0, 1, 32'h500);
        add(0, 0, 32'h0,         0,  0, 32'h0,        dat(32'h500),      32'h500,       1, 1, 32'h504);
        add(0, 1, 32'hFFFF_FFFC, 0,  0, 32'h0,        NOP,               32'h500,       0, 1, 32'h504);
        add(0, 0, 32'h0,         1,  0, 32'h0,        NOP,               32'h500,       0, 1, 32'hFFFF_FFFC);
        add(0, 0, 32'h0,         0,  1, 32'hFFFF_FFFC, NOP,              32'h500,       0, 0, 32'hFFFF_FFFC);
        add(0, 0, 32'h0,         1,  1, 32'h0,        NOP,               32'h500,       0, 1, 32'hFFFF_FFFC);
        add(0, 0, 32'h0,         0,  0, 32'h0,        dat(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1, 1, 32'h0);

        // Reset state while rst is held.
        #3;
        chk("rst_ir", ir, NOP);
        chk("rst_pc_id", pc_id, 32'h0);
        chk("rst_pc4_id", pc4_id, 32'h4);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_pc_sdu", pc_sdu, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            stall       = tbl[i].stall;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            imem_rvalid = tbl[i].rv;
            imem_rdata  = dat(last_addr);
            #1;
            chk($sformatf("row%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].ereq});
            if (tbl[i].ereq)
                chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].eaddr);
            chk($sformatf("row%0d_ir", i), ir, tbl[i].eir);
            chk($sformatf("row%0d_pc_id", i), pc_id, tbl[i].epcid);
            chk($sformatf("row%0d_pc4_id", i), pc4_id, tbl[i].epcid + 32'd4);
            chk($sformatf("row%0d_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].evalid});
            chk($sformatf("row%0d_busy", i), {31'd0, fetch_busy}, {31'd0, tbl[i].ebusy});
            chk($sformatf("row%0d_pc_sdu", i), pc_sdu, tbl[i].epcf);
            $display("[TB] row %0d: req=%0b addr=%08h ir=%08h pc_id=%08h valid=%0b",
                     i, imem_req, imem_addr, ir, pc_id, id_valid);
            req_s  = imem_req;
            addr_s = imem_addr;
            @(posedge clk); #1;
            if (req_s) last_addr = addr_s;
        end

        // Asynchronous reset between edges while a request to 0x0 is outstanding.
        stall = 1'b0; redirect = 1'b0; imem_rvalid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ir", ir, NOP);
        chk("arst_valid", {31'd0, id_valid}, 32'd0);
        chk("arst_pc_id", pc_id, 32'h0);
        chk("arst_pc4_id", pc4_id, 32'h4);
        chk("arst_busy", {31'd0, fetch_busy}, 32'd0);
        chk("arst_pc_sdu", pc_sdu, 32'h0);
        $display("[TB] async reset: ir=%08h valid=%0b busy=%0b", ir, id_valid, fetch_busy);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
        @(posedge clk); #1;
        imem_rvalid = 1'b1;
        imem_rdata  = dat(32'h0);
        #1;
        chk("post_rst_next_addr", imem_addr, 32'h4);
        chk("post_rst_busy", {31'd0, fetch_busy}, 32'd1);
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        #1;
        chk("post_rst_ir", ir, dat(32'h0));
        chk("post_rst_valid", {31'd0, id_valid}, 32'd1);
        chk("post_rst_pc4_id", pc4_id, 32'h4);
        $display("[TB] after reset: ir=%08h pc_id=%08h valid=%0b", ir, pc_id, id_valid);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
